ttt_move_scheduler: RTL

//  Owns the 3x3 board register file. Arbitrates move requests between player 1 and player 2.

---
 rtl/ttt_pkg.sv | 31 +++
 rtl/ttt_line_check.sv | 21 ++
 rtl/ttt_move_scheduler.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
// Shared types and tables for the tic-tac-toe move scheduler.
// State encoding, cell codes and the win-line cell table.
package ttt_pkg;

  typedef enum logic [1:0] {
    P1_TURN = 2'd0,
    P2_TURN = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  // rows 0-2, cols 3-5, diagonal 6, anti-diagonal 7
  localparam logic [3:0] LINE_TBL [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

endpackage

// File: rtl/ttt_line_check.sv
// Combinational single-line matcher: true when all three cells
// of the selected win line hold the given player code.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [17:0] board_i,
  input  logic [2:0]  line_i,
  input  logic [1:0]  code_i,
  output logic        match_o
);

  // compare the three cells of the selected line against the code
  always_comb begin
    match_o = 1'b1;
    for (int j = 0; j < 3; j++) begin
      if (board_i[{LINE_TBL[line_i][j], 1'b0} +: 2] != code_i)
        match_o = 1'b0;
    end
  end

endmodule

// File: rtl/ttt_move_scheduler.sv
// Board owner, move arbiter and sequential win/draw scanner.
// Optional turn forfeit timer enabled by defining MOVE_TIMEOUT_EN.
module ttt_move_scheduler
  import ttt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TO_W           = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        p1_req,
  input  logic [3:0]  p1_cell,
  input  logic        p2_req,
  input  logic [3:0]  p2_cell,
  output logic        move_ack,
  output logic        move_nack,
  output logic        player1_turn,
  output logic        player2_turn,
  output logic        busy,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        draw,
  output logic [17:0] board,
  output logic        timeout
);

  state_e      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic [2:0]  line_q, line_d;
  logic [1:0]  mover_q, mover_d;
  logic [1:0]  winner_q, winner_d;
  logic        draw_q, draw_d;
  logic        ack_q, ack_d;
  logic        nack_q, nack_d;
  logic        tmo_q, tmo_d;

  logic        req;
  logic [3:0]  req_cell;
  logic [1:0]  req_code;
  logic        cell_ok;
  logic        cell_free;
  logic        full;
  logic        match;
  logic        expire;

  ttt_line_check u_line (
    .board_i (board_q),
    .line_i  (line_q),
    .code_i  (mover_q),
    .match_o (match)
  );

  // select the active player's request and inspect the target cell
  always_comb begin
    req       = 1'b0;
    req_cell  = p1_cell;
    req_code  = CELL_P1;
    cell_ok   = 1'b0;
    cell_free = 1'b0;
    full      = 1'b1;
    if (state_q == P1_TURN) begin
      req = p1_req;
    end else if (state_q == P2_TURN) begin
      req      = p2_req;
      req_cell = p2_cell;
      req_code = CELL_P2;
    end
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (board_q[2*i +: 2] == CELL_EMPTY)
        full = 1'b0;
      if (req_cell == 4'(i)) begin
        cell_ok   = 1'b1;
        cell_free = (board_q[2*i +: 2] == CELL_EMPTY);
      end
    end
  end

`ifdef MOVE_TIMEOUT_EN
  logic [TO_W-1:0] to_q;

  assign expire = (to_q == TO_W'(TIMEOUT_CYCLES - 1));

  // count cycles spent in the current turn; restart on any turn entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      to_q <= '0;
    else if ((state_q == P1_TURN || state_q == P2_TURN) &&
             state_d == state_q && !new_game)
      to_q <= to_q + 1'b1;
    else
      to_q <= '0;
  end
`else
  localparam int to_cfg_unused = TIMEOUT_CYCLES + TO_W;
  assign expire = 1'b0;
`endif

  // next state and datapath updates
  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    line_d   = line_q;
    mover_d  = mover_q;
    winner_d = winner_q;
    draw_d   = draw_q;
    ack_d    = 1'b0;
    nack_d   = 1'b0;
    tmo_d    = 1'b0;
    if (new_game) begin
      state_d  = P1_TURN;
      board_d  = '0;
      line_d   = '0;
      winner_d = CELL_EMPTY;
      draw_d   = 1'b0;
    end else begin
      unique case (state_q)
        P1_TURN, P2_TURN: begin
          if (expire) begin
            tmo_d   = 1'b1;
            state_d = (state_q == P1_TURN) ? P2_TURN : P1_TURN;
          end else if (req) begin
            if (cell_ok && cell_free) begin
              for (int i = 0; i < NUM_CELLS; i++)
                if (req_cell == 4'(i))
                  board_d[2*i +: 2] = req_code;
              ack_d   = 1'b1;
              mover_d = req_code;
              line_d  = '0;
              state_d = CHECK;
            end else begin
              nack_d = 1'b1;
            end
          end
        end
        CHECK: begin
          if (match) begin
            state_d  = DONE;
            winner_d = mover_q;
          end else if (line_q == 3'(NUM_LINES - 1)) begin
            if (full) begin
              state_d = DONE;
              draw_d  = 1'b1;
            end else begin
              state_d = (mover_q == CELL_P1) ? P2_TURN : P1_TURN;
            end
          end else begin
            line_d = line_q + 3'd1;
          end
        end
        DONE: begin
        end
        default: state_d = P1_TURN;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= P1_TURN;
    else
      state_q <= state_d;
  end

  // board, scan and registered result state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      board_q  <= '0;
      line_q   <= '0;
      mover_q  <= CELL_P1;
      winner_q <= CELL_EMPTY;
      draw_q   <= 1'b0;
      ack_q    <= 1'b0;
      nack_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      board_q  <= board_d;
      line_q   <= line_d;
      mover_q  <= mover_d;
      winner_q <= winner_d;
      draw_q   <= draw_d;
      ack_q    <= ack_d;
      nack_q   <= nack_d;
      tmo_q    <= tmo_d;
    end
  end

  // state decode and output drive
  always_comb begin
    player1_turn = (state_q == P1_TURN);
    player2_turn = (state_q == P2_TURN);
    busy         = (state_q == CHECK);
    game_over    = (state_q == DONE);
    move_ack     = ack_q;
    move_nack    = nack_q;
    winner       = winner_q;
    draw         = draw_q;
    board        = board_q;
    timeout      = tmo_q;
  end

endmodule
